// File: rtl/shift_pkg.sv
// Shared definitions for the shift_reg / shift_deser serial link.
// Holds the receiver state encoding and the bit-order convention.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Both ends of the link send and capture the most significant bit first.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Frame bit counter: counts accepted samples, flags the final data bit.
// Latency: cnt updates one clock after en; last is combinational from cnt.
// Backpressure: en low (pause) holds the count; clr takes priority over en.
module shift_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_deser.sv
// Serial-in parallel-out receiver, MSB first; optional even parity via SHIFT_DESER_PARITY_EN.
// Latency: valid pulses WIDTH (+1 with parity) clocks after start, plus paused cycles.
// Backpressure: pause freezes shift register, counter and state; start is ignored while paused or busy.
module shift_deser
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_DESER_PARITY_EN
    localparam state_e AFTER_LAST = PAR;
`else
    localparam state_e AFTER_LAST = IDLE;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             sample;
    logic             final_bit;

    if (WIDTH == 1) begin : g_w1
        assign shift_nxt = serial_in;
    end else begin : g_wn
        assign shift_nxt = {shreg_q[WIDTH-2:0], serial_in};
    end

    always_comb begin
        sample = 1'b0;
        case (state_q)
            IDLE:    sample = start & ~pause;
            SHIFT:   sample = ~pause;
            default: sample = 1'b0;
        endcase
    end

    // In IDLE the count is 0, so cnt_last there only fires for WIDTH=1.
    assign final_bit = sample & cnt_last;

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sample),
        .clr   (final_bit),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample) state_d = cnt_last ? AFTER_LAST : SHIFT;
            SHIFT:   if (final_bit) state_d = AFTER_LAST;
            PAR:     if (!pause) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SHIFT_DESER_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        shreg_d      = sample ? shift_nxt : shreg_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        if (state_q == PAR && !pause) begin
            data_out_d   = shreg_q;
            valid_d      = 1'b1;
            parity_err_d = ^{shreg_q, serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    always_comb begin
        shreg_d    = sample ? shift_nxt : shreg_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        if (final_bit) begin
            data_out_d = shift_nxt;
            valid_d    = 1'b1;
        end
    end

    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (WIDTH=4); parity cases compile in with SHIFT_DESER_PARITY_EN.
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       start;
    logic       pause;
    logic [3:0] data_out;
    logic       valid;
    logic       busy;
    logic       parity_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    shift_deser #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .start      (start),
        .pause      (pause),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    // Drive one cycle's inputs, then move to 1 time unit after the next edge.
    task automatic cyc(input logic s, input logic si, input logic p);
        start     = s;
        serial_in = si;
        pause     = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Feed the four data bits of a frame, MSB first, start on the first.
    task automatic frame4(input logic [3:0] w);
        cyc(1'b1, w[3], 1'b0);
        cyc(1'b0, w[2], 1'b0);
        cyc(1'b0, w[1], 1'b0);
        cyc(1'b0, w[0], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; serial_in = 1'b0; pause = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_data", data_out, 4'h0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", parity_err, 0);
        rst_n = 1'b1;

        // 1: plain frame 1101
        cyc(1, 1, 0);
        chk("t1_busy_c1", busy, 1);
        chk("t1_valid_c1", valid, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("t1_valid_c3", valid, 0);
        cyc(0, 1, 0);
`ifdef SHIFT_DESER_PARITY_EN
        chk("t1_valid_c4", valid, 0);
        cyc(0, 1, 0);
`endif
        chk("t1_valid", valid, 1);
        chk("t1_data", data_out, 4'b1101);
        chk("t1_busy_c4", busy, 0);
`ifndef SHIFT_DESER_PARITY_EN
        chk("t1_perr", parity_err, 0);
`endif
        cyc(0, 0, 0);
        chk("t1_valid_drop", valid, 0);
        chk("t1_data_hold", data_out, 4'b1101);

        // 2: same frame, paused in cycles 2 and 3 with garbage on serial_in
        cyc(1, 1, 0);
        chk("t2_busy_c1", busy, 1);
        cyc(0, 1, 0);
        chk("t2_busy_c2", busy, 1);
        cyc(0, 0, 1);
        chk("t2_busy_c3", busy, 1);
        cyc(0, 1, 1);
        chk("t2_busy_c4", busy, 1);
        chk("t2_valid_c4", valid, 0);
        cyc(0, 0, 0);
        chk("t2_busy_c5", busy, 1);
        chk("t2_valid_c5", valid, 0);
        cyc(0, 1, 0);
`ifdef SHIFT_DESER_PARITY_EN
        cyc(0, 1, 0);
`endif
        chk("t2_valid", valid, 1);
        chk("t2_data", data_out, 4'b1101);
        chk("t2_busy_c6", busy, 0);

        // 3: back-to-back 1010 then 0111
        frame4(4'b1010);
`ifdef SHIFT_DESER_PARITY_EN
        cyc(0, 0, 0);
`endif
        chk("t3_valid_a", valid, 1);
        chk("t3_data_a", data_out, 4'b1010);
        cyc(1, 0, 0);
        chk("t3_valid_gap1", valid, 0);
        chk("t3_busy_b", busy, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("t3_valid_gap3", valid, 0);
        cyc(0, 1, 0);
`ifdef SHIFT_DESER_PARITY_EN
        cyc(0, 1, 0);
`endif
        chk("t3_valid_b", valid, 1);
        chk("t3_data_b", data_out, 4'b0111);

        // 4: reset after two bits of 1111, then frame 0011
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        rst_n = 1'b0;
        cyc(0, 1, 0);
        rst_n = 1'b1;
        chk("t4_data_rst", data_out, 4'h0);
        chk("t4_valid_rst", valid, 0);
        chk("t4_busy_rst", busy, 0);
        cyc(0, 1, 0);
        chk("t4_valid_after", valid, 0);
        frame4(4'b0011);
`ifdef SHIFT_DESER_PARITY_EN
        cyc(0, 0, 0);
`endif
        chk("t4_valid", valid, 1);
        chk("t4_data", data_out, 4'b0011);

        // 5: start while paused is dropped; start mid-frame has no effect
        cyc(1, 1, 1);
        chk("t5_busy_paused_start", busy, 0);
        cyc(0, 0, 0);
        chk("t5_valid_none", valid, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t5_busy_mid", busy, 1);
        cyc(1, 1, 0);
`ifdef SHIFT_DESER_PARITY_EN
        cyc(0, 0, 0);
`endif
        chk("t5_valid", valid, 1);
        chk("t5_data", data_out, 4'b1001);
        chk("t5_busy_end", busy, 0);
        cyc(0, 0, 0);
        chk("t5_busy_idle", busy, 0);

`ifdef SHIFT_DESER_PARITY_EN
        // 6: parity good, parity bad (held), then good again clears it
        frame4(4'b1101);
        chk("t6_valid_c4", valid, 0);
        chk("t6_busy_par", busy, 1);
        cyc(0, 1, 0);
        chk("t6_valid_ok", valid, 1);
        chk("t6_perr_ok", parity_err, 0);
        frame4(4'b1101);
        cyc(0, 0, 0);
        chk("t6_valid_bad", valid, 1);
        chk("t6_perr_bad", parity_err, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t6_perr_hold", parity_err, 1);
        frame4(4'b0000);
        cyc(0, 0, 1);
        chk("t6_par_paused", valid, 0);
        chk("t6_perr_paused", parity_err, 1);
        cyc(0, 0, 0);
        chk("t6_valid_clr", valid, 1);
        chk("t6_perr_clr", parity_err, 0);
        chk("t6_data_clr", data_out, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in, parallel-out receiver; the capture end of the parallel-load, serial-out `shift_reg` link.
- Samples one bit per `clk` from `serial_in`, MSB first, framed by a `start` strobe coinciding with the first bit.
- Honours the same `pause` freeze semantics as the transmitter.
- Presents each completed word on `data_out` with a one-cycle `valid` pulse.

Parameters:
- WIDTH, 4, bits per frame (legal 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- serial_in  input  1  serial data, MSB first.
- start  input  1  frame strobe; high on the cycle the MSB is on `serial_in`.
- pause  input  1  freeze: no sampling, counter and state hold.
- data_out  output  WIDTH  last completed word.
- valid  output  1  one-cycle pulse, `data_out` newly updated.
- busy  output  1  frame in progress (state != IDLE).
- parity_err  output  1  parity mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, shreg=0, cnt=0.
  - data_out=0, valid=0, busy=0, parity_err=0.
  - Reset mid-frame abandons the partial word; no valid pulse.
- Every sample shifts left: shreg <= {shreg[WIDTH-2:0], serial_in}. For WIDTH=1: shreg <= serial_in.
- States: IDLE, SHIFT, PAR (PAR exists only with the feature).
- IDLE:
  - If start=1 and pause=0: sample the bit, cnt<=1, go to SHIFT.
  - If WIDTH=1, treat as the final bit instead (see final-bit rule).
  - start while pause=1 is ignored; the frame is not accepted.
- SHIFT:
  - If pause=0: sample the bit, cnt<=cnt+1.
  - The sample taken when cnt==WIDTH-1 is the final bit.
  - start is ignored while in SHIFT; there is no resync.
- Final-bit rule, without feature:
  - On the same edge: data_out<={shreg[WIDTH-2:0],serial_in}, valid<=1, state<=IDLE, cnt<=0.
  - valid is therefore high in the cycle after the final bit was sampled.
- valid:
  - Deasserts after exactly one cycle, regardless of pause.
  - data_out holds until the next completed frame.
- Latency: valid asserts WIDTH + (number of paused cycles) clocks after the start cycle.
- Back-to-back frames:
  - start may be asserted in the cycle valid is high (state is already IDLE).
  - No bubble is required.
- pause:
  - Held indefinitely mid-frame, it freezes shreg, cnt and state.
  - The bit on `serial_in` during a paused cycle is never sampled.
- busy = (state != IDLE), combinational from the state register.
- cnt width: $clog2(WIDTH+1), with no wrap. cnt never exceeds WIDTH-1 in SHIFT.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - After the final data bit, go to PAR instead of completing.
  - Data is not yet published.
  - In PAR with pause=0: sample the parity bit, compute even parity (XOR of the WIDTH data bits and the parity bit must be 0).
  - On that edge: data_out updates, valid<=1, parity_err<=mismatch, state<=IDLE.
  - pause freezes PAR.
  - parity_err holds until the next valid edge.
  - Latency becomes WIDTH+1 plus paused cycles.
- Undefined:
  - No PAR state; parity_err is tied 0.
  - Frame length is WIDTH.

Decomposition:
- Package shift_pkg:
  - state enum (IDLE, SHIFT, PAR).
  - Default WIDTH constant.
  - MSB_FIRST convention constant shared with the transmitter.
- One natural sub-module: shift_bit_counter (parameterised up-counter with enable=!pause and sync clear, terminal flag at WIDTH-1).
- Shift register and FSM stay in shift_deser.

Test Plan:
1. WIDTH=4, rst_n low 2 cycles then high; start=1 with serial_in=1 in cycle 0, then bits 1,0,1 in cycles 1..3 -> valid=1 in cycle 4 only, data_out=4'b1101, busy low in cycle 4.
2. Same frame with pause=1 during cycles 2 and 3 (serial_in toggled garbage while paused) -> data_out=4'b1101, valid in cycle 6, busy high cycles 1..5.
3. Two back-to-back frames 4'b1010 then 4'b0111, second start in the valid cycle of the first -> two valid pulses 4 cycles apart, data_out 4'b1010 then 4'b0111.
4. rst_n low for one cycle after 2 bits of frame 4'b1111 -> all outputs 0, no valid; a following full frame 4'b0011 -> data_out=4'b0011.
5. start asserted with pause=1 in IDLE, then start mid-frame in SHIFT -> first start ignored (busy stays 0); mid-frame start has no effect on data 4'b1001.
6. With SHIFT_DESER_PARITY_EN: frame 4'b1101 + parity 1 -> valid in cycle 5, parity_err=0; frame 4'b1101 + parity 0 -> parity_err=1, held until next valid.
